// File: rtl/adder_result_sink.sv
// -----------------------------------------------------------------------------
// adder_result_sink
//
// Purpose:
//   Output-side companion of the adder IP. The adder has no backpressure, so
//   every result it presents (res_valid/res_sum/res_carry) is captured into a
//   small show-ahead FIFO. The FIFO is drained downstream over a valid/ready
//   handshake. A result that arrives while the FIFO is full and not being
//   popped is dropped, and a sticky overflow flag records the loss.
//
// Parameters:
//   DATA_WIDTH : width of the sum (>= 1)
//   FIFO_DEPTH : number of result entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n      : clock (posedge) and asynchronous active-low reset
//   res_valid       : adder result valid, no ready path back to the adder
//   res_sum         : adder sum
//   res_carry       : adder carry-out
//   m_valid         : head-of-FIFO result available
//   m_ready         : downstream accepts the head result
//   m_sum, m_carry  : head-of-FIFO result, driven 0 while empty
//   level           : current occupancy, 0..FIFO_DEPTH
//   overflow        : sticky, set when a result is dropped
//   clr_overflow    : synchronous clear of overflow (a same-cycle drop wins)
//   drop_count      : dropped-result count, saturating at 16'hFFFF
//   accept_count    : accepted-result count, wraps at 2^32
//
// Configuration:
//   ADDER_RSP_STATS_EN : when defined, builds the drop/accept counters.
//                        When undefined, drop_count/accept_count are tied to 0.
// -----------------------------------------------------------------------------
module adder_result_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            res_valid,
    input  logic [DATA_WIDTH-1:0]           res_sum,
    input  logic                            res_carry,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [DATA_WIDTH-1:0]           m_sum,
    output logic                            m_carry,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            overflow,
    input  logic                            clr_overflow,
    output logic [15:0]                     drop_count,
    output logic [31:0]                     accept_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    // Each entry stores {carry, sum}.
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0] head;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;

    logic push;
    logic pop;
    logic drop;

    // Full/empty come from the occupancy count, so pointer equality never has
    // to be disambiguated. A pop in the same cycle frees a slot, which lets a
    // push land even when the FIFO is full.
    always_comb begin
        pop  = (level_q != '0) && m_ready;
        push = res_valid && ((level_q < FULL_LVL) || pop);
        drop = res_valid && !push;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // Pointers are PW bits wide, so +1 wraps modulo FIFO_DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; level_q gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {res_carry, res_sum};
        end
    end

    // Show-ahead head: outputs depend only on registered state, so a new
    // result is visible the cycle after it is written and reset clears
    // m_valid asynchronously through level_q.
    always_comb begin
        head    = mem[rd_ptr_q];
        m_valid = (level_q != '0);
        m_sum   = m_valid ? head[DATA_WIDTH-1:0] : '0;
        m_carry = m_valid ? head[DATA_WIDTH] : 1'b0;
    end

    assign level    = level_q;
    assign overflow = overflow_q;

`ifdef ADDER_RSP_STATS_EN
    logic [31:0] accept_count_q, accept_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        accept_count_d = accept_count_q;
        drop_count_d   = drop_count_q;
        if (push) begin
            accept_count_d = accept_count_q + 32'd1;
        end
        // Saturate rather than wrap so a large loss is never reported as small.
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accept_count_q <= '0;
            drop_count_q   <= '0;
        end else begin
            accept_count_q <= accept_count_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign accept_count = accept_count_q;
    assign drop_count   = drop_count_q;
`else
    assign accept_count = '0;
    assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_adder_result_sink.sv
module tb_adder_result_sink;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef ADDER_RSP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          res_valid = 1'b0;
    logic [DW-1:0] res_sum = '0;
    logic          res_carry = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_sum;
    logic          m_carry;
    logic [2:0]    level;
    logic          overflow;
    logic          clr_overflow = 1'b0;
    logic [15:0]   drop_count;
    logic [31:0]   accept_count;

    adder_result_sink #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_valid    (res_valid),
        .res_sum      (res_sum),
        .res_carry    (res_carry),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_sum        (m_sum),
        .m_carry      (m_carry),
        .level        (level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .drop_count   (drop_count),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {carry,sum} in arrival order, plus the
    // sticky flag and counters, advanced once per clock edge.
    logic [DW:0] mq[$];
    bit          m_ovf = 1'b0;
    longint      m_acc = 0;
    longint      m_drp = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
            m_acc = 0;
            m_drp = 0;
        end else begin
            bit popped;
            bit taken;
            popped = (mq.size() != 0) && m_ready;
            taken  = res_valid && ((mq.size() < DEPTH) || popped);
            if (popped) void'(mq.pop_front());
            if (taken) begin
                mq.push_back({res_carry, res_sum});
                m_acc = (m_acc + 1) % 64'h1_0000_0000;
            end
            if (res_valid && !taken) begin
                m_ovf = 1'b1;
                if (m_drp < 65535) m_drp++;
            end else if (clr_overflow) begin
                m_ovf = 1'b0;
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [DW:0] hd;
            bit          ev;
            ev = (mq.size() != 0);
            hd = ev ? mq[0] : '0;
            chk("m_valid", m_valid, ev);
            chk("level", level, mq.size());
            chk("m_sum", m_sum, hd[DW-1:0]);
            chk("m_carry", m_carry, hd[DW]);
            chk("overflow", overflow, m_ovf);
            chk("accept_count", accept_count, STATS ? m_acc : 0);
            chk("drop_count", drop_count, STATS ? m_drp : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic push_val(input logic [DW-1:0] v, input logic c);
        res_valid = 1'b1;
        res_sum   = v;
        res_carry = c;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        #3;
        do_reset();
        chk_en = 1'b1;

        // Reset state
        chk("rst_m_valid", m_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_m_sum", m_sum, 0);
        chk("rst_overflow", overflow, 0);

        // Single push then pop
        push_val(32'h5, 1'b0);
        chk("single_valid", m_valid, 1);
        chk("single_sum", m_sum, 32'h5);
        chk("single_level", level, 1);
        m_ready = 1'b1;
        tick();
        chk("single_pop_valid", m_valid, 0);
        chk("single_pop_level", level, 0);
        m_ready = 1'b0;

        // Fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) push_val(DW'(i), 1'b0);
        chk("full_level", level, 4);
        push_val(32'h5, 1'b0);
        chk("drop_overflow", overflow, 1);
        chk("drop_level", level, 4);
        chk("drop_count_lit", drop_count, STATS ? 1 : 0);
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", m_sum, i);
            tick();
        end
        chk("drained_level", level, 0);
        m_ready = 1'b0;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("clr_overflow", overflow, 0);

        // Full with simultaneous pop and push
        for (int i = 1; i <= 4; i++) push_val(DW'(i), 1'b0);
        m_ready = 1'b1;
        push_val(32'h9, 1'b0);
        chk("fullpop_level", level, 4);
        chk("fullpop_overflow", overflow, 0);
        begin
            logic [DW-1:0] exp_ord [4];
            exp_ord = '{32'h2, 32'h3, 32'h4, 32'h9};
            for (int i = 0; i < 4; i++) begin
                chk("fullpop_order", m_sum, exp_ord[i]);
                tick();
            end
        end
        m_ready = 1'b0;

        // Drop and clear in the same cycle: set wins
        for (int i = 1; i <= 4; i++) push_val(DW'(i), 1'b0);
        clr_overflow = 1'b1;
        push_val(32'h7, 1'b0);
        chk("drop_clr_overflow", overflow, 1);
        tick();
        clr_overflow = 1'b0;
        chk("clr_alone_overflow", overflow, 0);
        m_ready = 1'b1;
        repeat (4) tick();
        m_ready = 1'b0;

        // Streaming with m_ready held high, carry alternating
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_val(DW'(32'h100 + i), 1'(i & 1));
            chk("stream_level_le1", level <= 1, 1);
            chk("stream_sum", m_sum, 32'h100 + i);
            chk("stream_carry", m_carry, i & 1);
        end
        chk("stream_accept", accept_count, STATS ? 10 : 0);
        tick();
        m_ready = 1'b0;

        // Reset mid-stream at level 3
        for (int i = 0; i < 3; i++) push_val(DW'(32'hA0 + i), 1'b1);
        chk("pre_rst_level", level, 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", m_valid, 0);
        chk("async_rst_level", level, 0);
        tick();
        rst_n = 1'b1;
        tick();
        push_val(32'h77, 1'b0);
        chk("post_rst_first", m_sum, 32'h77);
        chk("post_rst_valid", m_valid, 1);
        m_ready = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            res_valid    = ($urandom_range(0, 3) != 0);
            res_sum      = $urandom;
            res_carry    = 1'($urandom);
            m_ready      = ($urandom_range(0, 2) == 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            tick();
        end
        res_valid    = 1'b0;
        clr_overflow = 1'b0;
        m_ready      = 1'b1;
        repeat (6) tick();
        chk("final_level", level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
